dual_slope_ctrl: RTL
====================

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of all phase counts and result.
REQ-002 Parameter AZ_CYCLES, default 256: auto-zero phase length in clocks; only used when DUAL_SLOPE_AZ_EN is defined.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  conversion request; sampled only in IDLE.
REQ-006 abort_i  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-007 comp_i  input  1  asynchronous zero-cross comparator; 1 = integrator output above zero.
REQ-008 t_int_i  input  CNT_W  integrate-phase length in clocks; latched at start.
REQ-009 t_max_i  input  CNT_W  de-integrate timeout in clocks; latched at start.
REQ-010 sw_in_o  output  1  connects the unknown input to the integrator.
REQ-011 sw_ref_o  output  1  connects the reference to the integrator.
REQ-012 ref_neg_o  output  1  reference polarity; 1 = negative reference.
REQ-013 sw_az_o  output  1  auto-zero switch.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 done_o  output  1  one-cycle pulse when result_o/ovf_o/neg_o are updated.
REQ-016 result_o  output  CNT_W  de-integrate count of the last conversion.
REQ-017 ovf_o  output  1  last conversion hit t_max_i.
REQ-018 neg_o  output  1  input polarity of the last conversion; 1 = negative.

Function
REQ-019 comp_i passes through a 2-flop synchronizer; only the synchronized value (comp_s) is used.
REQ-020 FSM states: IDLE, AZERO, INTEG, DEINT, DONE; transitions are registered, and switch outputs are a registered decode of the state.
REQ-021 IDLE and start_i=1: latch t_int_i and t_max_i, clear the phase counter, go to AZERO (macro defined) or INTEG (macro undefined).
REQ-022 AZERO: sw_az_o=1 for exactly AZ_CYCLES clocks, then go to INTEG.
REQ-023 INTEG: sw_in_o=1 for exactly t_int_i clocks; t_int_i=0 is treated as 1.
REQ-024 INTEG exit: latch neg_r = ~comp_s on the last INTEG cycle, then go to DEINT.
REQ-025 DEINT: sw_ref_o=1 and ref_neg_o=~neg_r; the counter starts at 0 and increments every clock.
REQ-026 DEINT ends on the first cycle where comp_s differs from its value at DEINT entry: result = count; ovf = 0.
REQ-027 DEINT also ends when count == t_max_i with no crossing: result = t_max_i; ovf = 1.
REQ-028 If the crossing and the timeout occur in the same cycle, the crossing wins (ovf = 0).
REQ-029 DONE lasts one cycle: all switches open, result_o/ovf_o/neg_o update, done_o=1, then go to IDLE.
REQ-030 The counter never wraps; it saturates at t_max_i.
REQ-031 At most one switch output is high in any cycle; the state decode guarantees break-before-make.
REQ-032 abort_i=1 in any state: go to IDLE next cycle, open all switches, no done_o pulse, and leave result_o unchanged.
REQ-033 start_i outside IDLE is ignored; start_i held high in IDLE starts back-to-back conversions.

Reset
REQ-034 rst_n_i low: state=IDLE and synchronizer flops = 0, asynchronously.
REQ-035 rst_n_i low: all outputs = 0 (including result_o, ovf_o, neg_o), asynchronously.
REQ-036 Reset mid-conversion: all switches open immediately and no done_o pulse is produced.

Configuration
REQ-037 Macro DUAL_SLOPE_AZ_EN defined: the AZERO state exists, and every conversion starts with AZ_CYCLES clocks of auto-zero.
REQ-038 Macro DUAL_SLOPE_AZ_EN undefined: the AZERO state and its counter logic are absent, sw_az_o is tied to 0, and IDLE goes directly to INTEG.

Structure
REQ-039 Package dual_slope_pkg holds the state enum and the CNT_W default.
REQ-040 One sub-module, phase_timer: a loadable CNT_W counter with clear, enable, and terminal-count compare, reused for all three phases.

Verification
REQ-041 Polarity and result: t_int=100, t_max=300, comp crosses 150 clocks into DEINT -> result_o=150+sync latency, ovf_o=0, neg_o=0, one done_o pulse.
REQ-042 Timeout: no crossing, t_max=50 -> result_o=50, ovf_o=1, DEINT lasts 51 clocks.
REQ-043 Same-cycle crossing and timeout: crossing coincides with count==t_max -> ovf_o=0.
REQ-044 Abort and mid-operation reset: abort in INTEG -> IDLE next clock, no done_o, result_o unchanged; reset in DEINT -> all outputs 0.
REQ-045 Configuration and switch exclusivity, both builds: AZ_EN defined -> sw_az_o high 256 clocks before sw_in_o; undefined -> sw_az_o constant 0; switch one-hot asserted on every cycle.

Source files
------------

// File: rtl/dual_slope_pkg.sv
// Shared types and defaults for the dual-slope ADC controller.
// The AZERO state only exists when DUAL_SLOPE_AZ_EN is defined.
package dual_slope_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int AZ_CYCLES_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef DUAL_SLOPE_AZ_EN
    S_AZERO,
`endif
    S_INTEG,
    S_DEINT,
    S_DONE
  } state_e;

endpackage

// File: rtl/dual_slope_ctrl_phase_timer.sv
// Phase counter shared by auto-zero, integrate and de-integrate.
// Counts up from zero and holds at the terminal value, so it never wraps.
module phase_timer
  import dual_slope_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == tc_val_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope integrating ADC sequencer: integrate for t_int, de-integrate until
// the comparator flips or t_max expires. Optional auto-zero via DUAL_SLOPE_AZ_EN.
module dual_slope_ctrl
  import dual_slope_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int AZ_CYCLES = AZ_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             comp_i,
  input  logic [CNT_W-1:0] t_int_i,
  input  logic [CNT_W-1:0] t_max_i,
  output logic             sw_in_o,
  output logic             sw_ref_o,
  output logic             ref_neg_o,
  output logic             sw_az_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] result_o,
  output logic             ovf_o,
  output logic             neg_o
);

  localparam logic [CNT_W-1:0] AZ_TC = CNT_W'(AZ_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] t_int_m1_q, t_int_m1_d, t_max_q, t_max_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             neg_r_q, neg_r_d, ovf_q, ovf_d, neg_q, neg_d;
  logic             sw_in_q, sw_in_d, sw_ref_q, sw_ref_d, ref_neg_q, ref_neg_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             comp_s, tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_cnt, tc_val;

  assign sync_d = {sync_q[0], comp_i};
  assign comp_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    t_int_m1_d = t_int_m1_q;
    t_max_d    = t_max_q;
    neg_r_d    = neg_r_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    neg_d      = neg_q;
    tmr_en     = 1'b0;
    tc_val     = AZ_TC;
    case (state_q)
      S_IDLE: if (start_i) begin
        t_int_m1_d = (t_int_i == '0) ? '0 : t_int_i - CNT_W'(1);
        t_max_d    = t_max_i;
`ifdef DUAL_SLOPE_AZ_EN
        state_d    = S_AZERO;
`else
        state_d    = S_INTEG;
`endif
      end
`ifdef DUAL_SLOPE_AZ_EN
      S_AZERO: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = S_INTEG;
      end
`endif
      S_INTEG: begin
        tmr_en = 1'b1;
        tc_val = t_int_m1_q;
        if (tmr_tc) begin
          neg_r_d = ~comp_s;
          state_d = S_DEINT;
        end
      end
      S_DEINT: begin
        tmr_en = 1'b1;
        tc_val = t_max_q;
        // comp_s at entry equals ~neg_r, so a crossing is comp_s == neg_r;
        // it is tested first so a crossing on the timeout cycle wins
        if (comp_s == neg_r_q) begin
          result_d = tmr_cnt;
          ovf_d    = 1'b0;
          neg_d    = neg_r_q;
          state_d  = S_DONE;
        end else if (tmr_tc) begin
          result_d = t_max_q;
          ovf_d    = 1'b1;
          neg_d    = neg_r_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      ovf_d    = ovf_q;
      neg_d    = neg_q;
    end
  end

  assign tmr_clr   = (state_d != state_q) || (state_q == S_IDLE);
  assign sw_in_d   = (state_d == S_INTEG);
  assign sw_ref_d  = (state_d == S_DEINT);
  assign ref_neg_d = sw_ref_d && !neg_r_d;
  assign busy_d    = (state_d != S_IDLE);
  assign done_d    = (state_d == S_DONE);

  phase_timer #(.W(CNT_W)) u_tmr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tc_val),
    .cnt_o    (tmr_cnt),
    .tc_o     (tmr_tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      t_int_m1_q <= '0;
      t_max_q    <= '0;
      neg_r_q    <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      neg_q      <= 1'b0;
      sw_in_q    <= 1'b0;
      sw_ref_q   <= 1'b0;
      ref_neg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      t_int_m1_q <= t_int_m1_d;
      t_max_q    <= t_max_d;
      neg_r_q    <= neg_r_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      neg_q      <= neg_d;
      sw_in_q    <= sw_in_d;
      sw_ref_q   <= sw_ref_d;
      ref_neg_q  <= ref_neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef DUAL_SLOPE_AZ_EN
  logic sw_az_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sw_az_q <= 1'b0;
    else          sw_az_q <= (state_d == S_AZERO);
  end
  assign sw_az_o = sw_az_q;
`else
  assign sw_az_o = 1'b0;
`endif

  assign sw_in_o   = sw_in_q;
  assign sw_ref_o  = sw_ref_q;
  assign ref_neg_o = ref_neg_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign ovf_o     = ovf_q;
  assign neg_o     = neg_q;

endmodule
